// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: operand/entry structs, tag widths and ALU opcodes.
// Tags are held zero-extended to TAG_MAX_W so the station's TAG_W can be overridden up to that width.
package alu_reservation_station_pkg;

   localparam int TAG_W_DEFAULT = 4;
   localparam int TAG_MAX_W     = 8;
   localparam int OP_W          = 10;
   localparam int DATA_W        = 32;

   typedef logic [TAG_MAX_W-1:0] tag_t;
   typedef logic [OP_W-1:0]      op_t;
   typedef logic [DATA_W-1:0]    data_t;

   typedef struct packed {
      logic  busy;
      tag_t  tag;
      data_t value;
   } operand_t;

   typedef struct packed {
      logic     valid;
      op_t      op;
      tag_t     dest;
      operand_t j;
      operand_t k;
   } entry_t;

   // Op = {funct7[6:0] compressed to Op[9:5], funct3 in Op[2:0]}; SUB/SRA set Op[5]
   localparam op_t OP_ADD  = 10'b0000000000;
   localparam op_t OP_SUB  = 10'b0000100000;
   localparam op_t OP_SLL  = 10'b0000000001;
   localparam op_t OP_SLT  = 10'b0000000010;
   localparam op_t OP_SLTU = 10'b0000000011;
   localparam op_t OP_XOR  = 10'b0000000100;
   localparam op_t OP_SRL  = 10'b0000000101;
   localparam op_t OP_SRA  = 10'b0000100101;
   localparam op_t OP_OR   = 10'b0000000110;
   localparam op_t OP_AND  = 10'b0000000111;

   function automatic logic entry_ready(input entry_t e);
      return e.valid && !e.j.busy && !e.k.busy;
   endfunction

endpackage

// File: rtl/alu_reservation_station_operand_capture.sv
// CDB wakeup for one operand: a busy operand whose tag matches the broadcast takes its value.
// Latency: combinational. Backpressure: none.
module rs_operand_capture
   import alu_reservation_station_pkg::*;
(
   input  operand_t operand,
   input  logic     cdb_valid,
   input  tag_t     cdb_tag,
   input  data_t    cdb_value,
   output operand_t captured
);

   always_comb begin
      captured = operand;
      if (cdb_valid && operand.busy && (operand.tag == cdb_tag)) begin
         captured.busy  = 1'b0;
         captured.value = cdb_value;
      end
   end

endmodule

// File: rtl/alu_reservation_station.sv
// Age-ordered compacting reservation station feeding the integer ALU; oldest ready entry dispatches.
// Latency: issue-to-dispatch and wakeup-to-dispatch 1 cycle. Backpressure: issue_ready = not full, no path from disp_ready.
module alu_reservation_station
   import alu_reservation_station_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = TAG_W_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       issue_valid,
   output logic                       issue_ready,
   input  logic [OP_W-1:0]            issue_op,
   input  logic [TAG_W-1:0]           issue_dest,
   input  logic                       issue_qj_busy,
   input  logic [TAG_W-1:0]           issue_qj,
   input  logic [DATA_W-1:0]          issue_vj,
   input  logic                       issue_qk_busy,
   input  logic [TAG_W-1:0]           issue_qk,
   input  logic [DATA_W-1:0]          issue_vk,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [DATA_W-1:0]          cdb_value,
   output logic                       disp_valid,
   input  logic                       disp_ready,
   output logic [DATA_W-1:0]          disp_vj,
   output logic [DATA_W-1:0]          disp_vk,
   output logic [OP_W-1:0]            disp_op,
   output logic [TAG_W-1:0]           disp_dest,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);

   entry_t           ent     [DEPTH];
   entry_t           woke    [DEPTH];
   entry_t           ent_nxt [DEPTH];
   operand_t         woke_j  [DEPTH];
   operand_t         woke_k  [DEPTH];
   operand_t         issue_j, issue_k, issue_j_woke, issue_k_woke;
   entry_t           issue_entry;
   tag_t             cdb_tag_ext;
   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic             fire, accept;
   logic [CNT_W-1:0] wr_idx;

   assign cdb_tag_ext = tag_t'(cdb_tag);
   assign issue_j     = '{busy: issue_qj_busy, tag: tag_t'(issue_qj), value: issue_vj};
   assign issue_k     = '{busy: issue_qk_busy, tag: tag_t'(issue_qk), value: issue_vk};

   for (genvar g = 0; g < DEPTH; g++) begin : g_wake
      rs_operand_capture u_cap_j (.operand(ent[g].j), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag_ext),
                                  .cdb_value(cdb_value), .captured(woke_j[g]));
      rs_operand_capture u_cap_k (.operand(ent[g].k), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag_ext),
                                  .cdb_value(cdb_value), .captured(woke_k[g]));
   end

   // Issue-time bypass: a broadcast in the issue cycle is captured by the incoming operands
   rs_operand_capture u_cap_issue_j (.operand(issue_j), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag_ext),
                                     .cdb_value(cdb_value), .captured(issue_j_woke));
   rs_operand_capture u_cap_issue_k (.operand(issue_k), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag_ext),
                                     .cdb_value(cdb_value), .captured(issue_k_woke));

   assign issue_entry = '{valid: 1'b1, op: issue_op, dest: tag_t'(issue_dest),
                          j: issue_j_woke, k: issue_k_woke};

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         woke[i]   = ent[i];
         woke[i].j = woke_j[i];
         woke[i].k = woke_k[i];
      end
   end

   // Selection sees registered state only, so a wakeup becomes eligible the following cycle
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (entry_ready(ent[i])) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      disp_vj   = '0;
      disp_vk   = '0;
      disp_op   = '0;
      disp_dest = '0;
      if (sel_found) begin
         disp_vj   = ent[sel_idx].j.value;
         disp_vk   = ent[sel_idx].k.value;
         disp_op   = ent[sel_idx].op;
         disp_dest = ent[sel_idx].dest[TAG_W-1:0];
      end
   end

   assign disp_valid  = sel_found;
   assign issue_ready = (count != CNT_W'(DEPTH));
   assign fire        = disp_valid && disp_ready;
   assign accept      = issue_valid && issue_ready;
   assign wr_idx      = count - CNT_W'(fire);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ent_nxt[i] = woke[i];
      if (fire) begin
         for (int i = 0; i < DEPTH-1; i++) begin
            if (i >= int'(sel_idx)) ent_nxt[i] = woke[i+1];
         end
         ent_nxt[DEPTH-1] = '0;
      end
      if (accept) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(wr_idx)) ent_nxt[i] = issue_entry;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else if (flush) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         count <= count + CNT_W'(accept) - CNT_W'(fire);
         for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_alu_reservation_station;
   import alu_reservation_station_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              rst_n, flush, issue_valid, issue_ready;
   logic [9:0]        issue_op;
   logic [TAG_W-1:0]  issue_dest, issue_qj, issue_qk, cdb_tag, disp_dest;
   logic              issue_qj_busy, issue_qk_busy, cdb_valid, disp_valid, disp_ready;
   logic [31:0]       issue_vj, issue_vk, cdb_value, disp_vj, disp_vk;
   logic [9:0]        disp_op;
   logic [2:0]        count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op), .issue_dest(issue_dest),
      .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj), .issue_vj(issue_vj),
      .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk), .issue_vk(issue_vk),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_vj(disp_vj), .disp_vk(disp_vk),
      .disp_op(disp_op), .disp_dest(disp_dest), .count(count));

   // Reference model: an ordered list of waiting instructions, oldest first
   typedef struct {
      logic [9:0]  op;
      logic [3:0]  dest;
      bit          jb;
      logic [3:0]  jt;
      logic [31:0] jv;
      bit          kb;
      logic [3:0]  kt;
      logic [31:0] kv;
   } m_ent_t;

   m_ent_t q[$];

   function automatic m_ent_t wake(input m_ent_t e);
      m_ent_t r = e;
      if (cdb_valid && r.jb && r.jt == cdb_tag) begin r.jb = 0; r.jv = cdb_value; end
      if (cdb_valid && r.kb && r.kt == cdb_tag) begin r.kb = 0; r.kv = cdb_value; end
      return r;
   endfunction

   function automatic int pick();
      for (int i = 0; i < q.size(); i++) if (!q[i].jb && !q[i].kb) return i;
      return -1;
   endfunction

   task automatic model_step();
      m_ent_t e;
      int     idx  = pick();
      bit     fire = (idx >= 0) && disp_ready;
      bit     acc  = issue_valid && (q.size() < DEPTH);
      if (flush) begin
         q.delete();
      end else begin
         foreach (q[i]) q[i] = wake(q[i]);
         if (fire) q.delete(idx);
         if (acc) begin
            e.op = issue_op; e.dest = issue_dest;
            e.jb = issue_qj_busy; e.jt = issue_qj; e.jv = issue_vj;
            e.kb = issue_qk_busy; e.kt = issue_qk; e.kv = issue_vk;
            q.push_back(wake(e));
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      flush = 0; issue_valid = 0; issue_op = '0; issue_dest = '0;
      issue_qj_busy = 0; issue_qj = '0; issue_vj = '0;
      issue_qk_busy = 0; issue_qk = '0; issue_vk = '0;
      cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
   endtask

   task automatic set_issue(input logic [9:0] op, input logic [3:0] dest,
                            input bit jb, input logic [3:0] jt, input logic [31:0] jv,
                            input bit kb, input logic [3:0] kt, input logic [31:0] kv);
      issue_valid = 1; issue_op = op; issue_dest = dest;
      issue_qj_busy = jb; issue_qj = jt; issue_vj = jv;
      issue_qk_busy = kb; issue_qk = kt; issue_vk = kv;
   endtask

   task automatic set_cdb(input logic [3:0] tag, input logic [31:0] value);
      cdb_valid = 1; cdb_tag = tag; cdb_value = value;
   endtask

   task automatic test_reset();
      rst_n = 0; disp_ready = 0;
      idle_inputs();
      #12;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %0b want 0", disp_valid); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %0b want 1", issue_ready); end
      checks++; if ({disp_vj, disp_vk, disp_op, disp_dest} !== '0) begin errors++; $display("FAIL reset_disp_data: got vj=%0h vk=%0h op=%0h dest=%0h want 0", disp_vj, disp_vk, disp_op, disp_dest); end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_ready_issue();
      set_issue(OP_ADD, 4'd3, 0, 4'd0, 32'd5, 0, 4'd0, 32'd7);
      tick();
      idle_inputs();
      checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL ready_valid: got %0b want 1", disp_valid); end
      checks++; if (disp_vj !== 32'd5 || disp_vk !== 32'd7) begin errors++; $display("FAIL ready_operands: got %0h/%0h want 5/7", disp_vj, disp_vk); end
      checks++; if (disp_dest !== 4'd3 || disp_op !== OP_ADD) begin errors++; $display("FAIL ready_dest_op: got %0d/%0h want 3/%0h", disp_dest, disp_op, OP_ADD); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL ready_count1: got %0d want 1", count); end
      disp_ready = 1;
      tick();
      disp_ready = 0;
      checks++; if (count !== 3'd0 || disp_valid !== 1'b0) begin errors++; $display("FAIL ready_drain: got count=%0d valid=%0b want 0/0", count, disp_valid); end
   endtask

   task automatic test_wakeup();
      set_issue(OP_SUB, 4'd4, 1, 4'd2, 32'hDEAD, 0, 4'd0, 32'd1);
      tick();
      idle_inputs();
      set_cdb(4'd5, 32'h55);
      checks++; if (disp_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL wake_pending: got valid=%0b count=%0d want 0/1", disp_valid, count); end
      tick();
      set_cdb(4'd2, 32'h10);
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL wake_wrong_tag: got valid=%0b want 0", disp_valid); end
      tick();
      idle_inputs();
      checks++; if (disp_valid !== 1'b1 || disp_vj !== 32'h10 || disp_vk !== 32'd1) begin errors++; $display("FAIL wake_capture: got valid=%0b vj=%0h vk=%0h want 1/10/1", disp_valid, disp_vj, disp_vk); end
      disp_ready = 1;
      tick();
      disp_ready = 0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL wake_drain: got %0d want 0", count); end
   endtask

   task automatic test_bypass();
      set_issue(OP_XOR, 4'd7, 0, 4'd0, 32'd3, 1, 4'd6, 32'd0);
      set_cdb(4'd6, 32'hFFFFFFFF);
      tick();
      idle_inputs();
      checks++; if (disp_valid !== 1'b1 || disp_vk !== 32'hFFFFFFFF || disp_vj !== 32'd3) begin errors++; $display("FAIL bypass_capture: got valid=%0b vj=%0h vk=%0h want 1/3/ffffffff", disp_valid, disp_vj, disp_vk); end
      disp_ready = 1;
      tick();
      disp_ready = 0;
      set_issue(OP_OR, 4'd8, 1, 4'd7, 32'd0, 1, 4'd7, 32'd0);
      tick();
      idle_inputs();
      set_cdb(4'd7, 32'hABCD);
      tick();
      idle_inputs();
      checks++; if (disp_valid !== 1'b1 || disp_vj !== 32'hABCD || disp_vk !== 32'hABCD) begin errors++; $display("FAIL both_match: got valid=%0b vj=%0h vk=%0h want 1/abcd/abcd", disp_valid, disp_vj, disp_vk); end
      disp_ready = 1;
      tick();
      disp_ready = 0;
   endtask

   task automatic test_age_order();
      set_issue(OP_ADD, 4'd11, 1, 4'd8, 32'd0, 0, 4'd0, 32'd2);  tick();
      set_issue(OP_SUB, 4'd1, 0, 4'd0, 32'hB0, 0, 4'd0, 32'd1);  tick();
      set_issue(OP_AND, 4'd10, 1, 4'd9, 32'd0, 0, 4'd0, 32'd3);  tick();
      set_issue(OP_OR, 4'd2, 0, 4'd0, 32'hD0, 0, 4'd0, 32'd4);   tick();
      idle_inputs();
      checks++; if (count !== 3'd4 || issue_ready !== 1'b0) begin errors++; $display("FAIL age_full: got count=%0d ready=%0b want 4/0", count, issue_ready); end
      checks++; if (disp_valid !== 1'b1 || disp_dest !== 4'd1 || disp_vj !== 32'hB0) begin errors++; $display("FAIL age_select_b: got valid=%0b dest=%0d vj=%0h want 1/1/b0", disp_valid, disp_dest, disp_vj); end
      disp_ready = 1;
      tick();
      checks++; if (count !== 3'd3 || issue_ready !== 1'b1 || disp_dest !== 4'd2) begin errors++; $display("FAIL age_after_b: got count=%0d ready=%0b dest=%0d want 3/1/2", count, issue_ready, disp_dest); end
      tick();
      checks++; if (count !== 3'd2 || disp_valid !== 1'b0) begin errors++; $display("FAIL age_after_d: got count=%0d valid=%0b want 2/0", count, disp_valid); end
      set_issue(OP_XOR, 4'd5, 0, 4'd0, 32'hE0, 0, 4'd0, 32'd5);
      set_cdb(4'd9, 32'hC0);
      tick();
      idle_inputs();
      checks++; if (count !== 3'd3 || disp_dest !== 4'd10 || disp_vj !== 32'hC0) begin errors++; $display("FAIL age_select_c: got count=%0d dest=%0d vj=%0h want 3/10/c0", count, disp_dest, disp_vj); end
      tick();
      checks++; if (count !== 3'd2 || disp_dest !== 4'd5) begin errors++; $display("FAIL age_after_c: got count=%0d dest=%0d want 2/5", count, disp_dest); end
      disp_ready = 0;
      set_cdb(4'd8, 32'hA0);
      tick();
      idle_inputs();
      checks++; if (disp_dest !== 4'd11 || disp_vj !== 32'hA0 || count !== 3'd2) begin errors++; $display("FAIL age_switch_older: got dest=%0d vj=%0h count=%0d want 11/a0/2", disp_dest, disp_vj, count); end
      tick();
      checks++; if (disp_valid !== 1'b1 || disp_dest !== 4'd11) begin errors++; $display("FAIL age_hold_stable: got valid=%0b dest=%0d want 1/11", disp_valid, disp_dest); end
      flush = 1;
      tick();
      flush = 0;
   endtask

   task automatic test_full();
      logic [3:0] order [3] = '{4'd3, 4'd4, 4'd9};
      int n = 0;
      disp_ready = 0;
      for (int d = 1; d <= 4; d++) begin
         set_issue(OP_ADD, 4'(d), 0, 4'd0, 32'(d * 16), 0, 4'd0, 32'd0);
         tick();
      end
      set_issue(OP_SUB, 4'd9, 0, 4'd0, 32'h90, 0, 4'd0, 32'd0);
      disp_ready = 1;
      checks++; if (count !== 3'd4 || issue_ready !== 1'b0) begin errors++; $display("FAIL full_state: got count=%0d ready=%0b want 4/0", count, issue_ready); end
      tick();
      checks++; if (count !== 3'd3 || disp_dest !== 4'd2) begin errors++; $display("FAIL full_issue_dropped: got count=%0d dest=%0d want 3/2", count, disp_dest); end
      tick();
      idle_inputs();
      checks++; if (count !== 3'd3 || disp_dest !== 4'd3) begin errors++; $display("FAIL full_issue_and_disp: got count=%0d dest=%0d want 3/3", count, disp_dest); end
      for (int c = 0; c < 10 && count != 0; c++) begin
         if (disp_valid === 1'b1 && n < 3) begin
            checks++; if (disp_dest !== order[n]) begin errors++; $display("FAIL full_drain_order[%0d]: got %0d want %0d", n, disp_dest, order[n]); end
            n++;
         end
         tick();
      end
      disp_ready = 0;
      checks++; if (n !== 3 || count !== 3'd0) begin errors++; $display("FAIL full_drain_done: got dispatched=%0d count=%0d want 3/0", n, count); end
   endtask

   task automatic test_flush();
      disp_ready = 0;
      set_issue(OP_ADD, 4'd1, 1, 4'd12, 32'd0, 0, 4'd0, 32'd1); tick();
      set_issue(OP_ADD, 4'd2, 0, 4'd0, 32'd2, 0, 4'd0, 32'd2);  tick();
      set_issue(OP_ADD, 4'd3, 0, 4'd0, 32'd3, 1, 4'd13, 32'd0); tick();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_fill: got %0d want 3", count); end
      set_issue(OP_SUB, 4'd4, 0, 4'd0, 32'd4, 0, 4'd0, 32'd4);
      flush = 1; disp_ready = 1;
      tick();
      idle_inputs();
      disp_ready = 0;
      checks++; if (count !== 3'd0 || disp_valid !== 1'b0 || issue_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got count=%0d valid=%0b ready=%0b want 0/0/1", count, disp_valid, issue_ready); end
      tick();
      checks++; if (count !== 3'd0 || disp_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_dropped: got count=%0d valid=%0b want 0/0", count, disp_valid); end
   endtask

   task automatic test_async_reset();
      set_issue(OP_AND, 4'd6, 0, 4'd0, 32'h66, 0, 4'd0, 32'h6); tick();
      set_issue(OP_OR, 4'd7, 0, 4'd0, 32'h77, 0, 4'd0, 32'h7);  tick();
      idle_inputs();
      checks++; if (count !== 3'd2 || disp_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got count=%0d valid=%0b want 2/1", count, disp_valid); end
      #2 rst_n = 0;
      #1;
      checks++; if (count !== 3'd0 || disp_valid !== 1'b0 || issue_ready !== 1'b1) begin errors++; $display("FAIL areset_immediate: got count=%0d valid=%0b ready=%0b want 0/0/1", count, disp_valid, issue_ready); end
      checks++; if (disp_vj !== 32'd0 || disp_dest !== 4'd0) begin errors++; $display("FAIL areset_data: got vj=%0h dest=%0d want 0/0", disp_vj, disp_dest); end
      q.delete();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_random();
      logic [9:0] ops [10] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
      int idx;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         idx = pick();
         checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, count, q.size()); end
         checks++; if (issue_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rand_issue_ready cyc %0d: got %0b want %0b", cyc, issue_ready, q.size() < DEPTH); end
         checks++; if (disp_valid !== (idx >= 0)) begin errors++; $display("FAIL rand_disp_valid cyc %0d: got %0b want %0b", cyc, disp_valid, idx >= 0); end
         if (idx >= 0) begin
            checks++; if ({disp_vj, disp_vk, disp_op, disp_dest} !== {q[idx].jv, q[idx].kv, q[idx].op, q[idx].dest}) begin errors++; $display("FAIL rand_disp_data cyc %0d: got %0h/%0h/%0h/%0d want %0h/%0h/%0h/%0d", cyc, disp_vj, disp_vk, disp_op, disp_dest, q[idx].jv, q[idx].kv, q[idx].op, q[idx].dest); end
         end else begin
            checks++; if ({disp_vj, disp_vk, disp_op, disp_dest} !== '0) begin errors++; $display("FAIL rand_disp_idle cyc %0d: got %0h/%0h/%0h/%0d want 0", cyc, disp_vj, disp_vk, disp_op, disp_dest); end
         end
         idle_inputs();
         if ($urandom_range(0, 9) < 6)
            set_issue(ops[$urandom_range(0, 9)], 4'($urandom), $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
                      $urandom_range(0, 1) == 1, 4'($urandom), $urandom);
         if ($urandom_range(0, 9) < 5) begin
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
               idx = $urandom_range(0, q.size() - 1);
               set_cdb(($urandom_range(0, 1) == 1) ? q[idx].jt : q[idx].kt, $urandom);
            end else begin
               set_cdb(4'($urandom), $urandom);
            end
         end
         flush      = ($urandom_range(0, 63) == 0);
         disp_ready = ($urandom_range(0, 9) < 5);
         tick();
      end
      idle_inputs();
      disp_ready = 0;
   endtask

   initial begin
      test_reset();
      test_ready_issue();
      test_wakeup();
      test_bypass();
      test_age_order();
      test_full();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station directly upstream of the integer ALU in the Tomasulo-style core.
- Accepts renamed ALU instructions from the issue stage and holds them until both operands are valid.
- Captures missing operands by snooping the common data bus (CDB).
- Dispatches the oldest ready entry's Vj/Vk/Op/destination tag to the ALU, which is combinational; its result goes to the CDB arbiter.

Parameters:
- DEPTH, 4, number of station entries (2..16).
- TAG_W, 4, width of producer/ROB tags.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries (branch mispredict).
- issue_valid  in  1  issue stage presents an instruction.
- issue_ready  out  1  station can accept this cycle.
- issue_op  in  10  ALU opcode (funct7/funct3 encoding, as consumed by the ALU).
- issue_dest  in  TAG_W  destination tag of the result.
- issue_qj_busy  in  1  1 = operand j still pending (value in issue_vj ignored).
- issue_qj  in  TAG_W  producer tag for operand j.
- issue_vj  in  32  operand j value when not busy.
- issue_qk_busy, issue_qk, issue_vk  in  1/TAG_W/32  same for operand k.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  32  broadcast value.
- disp_valid  out  1  a ready entry is presented to the ALU.
- disp_ready  in  1  downstream (ALU/result latch) accepts.
- disp_vj, disp_vk  out  32  operands to ALU Vj/Vk.
- disp_op  out  10  opcode to ALU Op.
- disp_dest  out  TAG_W  destination tag accompanying the result.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst_n low, asynchronous): all entries invalid; count=0; disp_valid=0; issue_ready=1; disp_* data outputs 0.
- Storage is an age-ordered compacting queue. Entry 0 is the oldest; valid entries are contiguous from index 0.
- Each entry holds:
  - op, dest
  - qj_busy, qj, vj
  - qk_busy, qk, vk
- Entry ready = valid and !qj_busy and !qk_busy.
- issue_ready = (count != DEPTH). It is registered-state derived and does not depend on disp_ready in the same cycle, so there is no combinational path from disp_ready.
- Issue accept (issue_valid && issue_ready):
  - The new entry is written at index count, or count-1 if a dispatch fires the same cycle.
- CDB wakeup: when cdb_valid and a busy operand's tag equals cdb_tag, that operand stores cdb_value and clears busy.
  - Applies to every stored entry.
  - Also applies to the incoming issue operand in the same cycle (issue-time bypass), so no broadcast is missed.
  - Operands that are not busy are never overwritten.
  - If qj and qk both match, both capture.
- Selection: disp_* reflect the lowest-index (oldest) ready entry, from registered state only. disp_valid=0 if none is ready; disp_* data then hold 0.
- A wakeup in cycle N makes the entry eligible in cycle N+1. Minimum issue-to-dispatch latency is 1 cycle.
- Dispatch fires on disp_valid && disp_ready:
  - The selected entry is removed.
  - Entries above it shift down by one, and their same-cycle CDB captures are applied to the shifted copies.
  - count decrements.
- disp_valid held high without disp_ready: outputs stay stable unless an older entry becomes ready. In that case selection may switch to the older entry; this is permitted because the ALU is combinational and has no handshake state.
- Simultaneous issue + dispatch: count unchanged. Simultaneous issue + dispatch while full is impossible, because issue_ready=0 when full.
- flush: all entries invalid, count=0 next cycle, and an issue in the same cycle is dropped. flush has priority over issue, dispatch and wakeup.
- count never exceeds DEPTH or underflows.

Decomposition:
- Shared package (e.g. core_pkg):
  - TAG_W default
  - operand struct {busy, tag, value}
  - station-entry struct {valid, op, dest, j, k}
  - ALU opcode constants (ADD=10'b0000000000, SUB=10'b0000100000, …) matching the ALU's Op[9:5] encoding
- One natural sub-module: rs_operand_capture. It takes the current operand and the CDB inputs and outputs the next operand, i.e. tag compare plus value mux. It is instantiated for every stored operand and for both issue operands.

Test Plan:
- Ready issue: reset, issue op=ADD, vj=5, vk=7, both not busy, dest=3 -> next cycle disp_valid=1, disp_vj=5, disp_vk=7, disp_dest=3. With disp_ready=1, count returns to 0.
- Wakeup: issue qj_busy=1 qj=2, vk=1. Then CDB tag=2 value=0x10 -> disp_valid=0 during the broadcast cycle, 1 the next cycle with disp_vj=0x10. CDB tag=5 causes no capture.
- Issue-time bypass: issue qk_busy=1 qk=6 in the same cycle as CDB tag=6 value=0xFFFFFFFF -> stored vk=0xFFFFFFFF, dispatched next cycle.
- Age order and compaction: fill 4 entries with A, B, C, D, where B and D are ready, disp_ready=0 -> disp selects B. Hold disp_ready=1 -> B then D dispatched. issue_ready rises when count=3. Wake C -> C dispatched before any newer entry.
- Full plus simultaneous: full station with dispatch and issue_valid asserted -> issue not accepted, count=3 next cycle. Next cycle, issue and dispatch together -> count stays 3.
- Flush and reset: flush with 3 entries and issue_valid=1 -> count=0, disp_valid=0. Assert rst_n low mid-operation -> outputs clear immediately, without waiting for a clock edge.
